// File: rtl/stim_step_sequencer.sv
// Purpose : plays back a table of (time stamp, 4-bit vector) steps onto i1..i4 against a prescaled timer.
// Latency : start at edge E0 -> busy after E0; step p with time T fires at E0+1+T*TICK_DIV (plus pause cycles).
// Flow    : no backpressure; pause freezes the time base, cfg writes are dropped while running.
// Ports   : clk/reset (sync, active-high); cfg_we/cfg_addr/cfg_time/cfg_vec table write port;
//           step_count/start/pause playback control; i1..i4, step_idx, step_strobe, busy, done outputs.
module stim_step_sequencer #(
  parameter int NUM_STEPS = 13,
  parameter int IDX_W     = 4,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [TIME_W-1:0] cfg_time,
  input  logic [3:0]        cfg_vec,
  input  logic [IDX_W:0]    step_count,
  input  logic              start,
  input  logic              pause,
  output logic              i1,
  output logic              i2,
  output logic              i3,
  output logic              i4,
  output logic [IDX_W-1:0]  step_idx,
  output logic              step_strobe,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W:0]  LEN_MAX = (IDX_W+1)'(NUM_STEPS);

  logic [TIME_W-1:0] tbl_time_q [NUM_STEPS];
  logic [3:0]        tbl_vec_q  [NUM_STEPS];

  logic [1:0]        state_q,    state_d;
  logic [IDX_W:0]    len_q,      len_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;
  logic [TIME_W-1:0] timer_q,    timer_d;
  logic [PRE_W-1:0]  pre_q,      pre_d;
  logic [3:0]        vec_q,      vec_d;
  logic [IDX_W-1:0]  step_idx_q, step_idx_d;
  logic              strobe_q,   strobe_d;

  logic cfg_ok;
  // Writes only land while not playing back and only for in-range entries.
  assign cfg_ok = cfg_we && (state_q != S_RUN) &&
                  ({1'b0, cfg_addr} < LEN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_time_q[i] <= '0;
        tbl_vec_q[i]  <= '0;
      end
    end else if (cfg_ok) begin
      tbl_time_q[cfg_addr] <= cfg_time;
      tbl_vec_q[cfg_addr]  <= cfg_vec;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    pre_d      = pre_q;
    vec_d      = vec_q;
    step_idx_d = step_idx_q;
    strobe_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A zero-length start is dropped; outputs keep their last vector.
        if (start && (step_count != '0)) begin
          state_d = S_RUN;
          len_d   = (step_count > LEN_MAX) ? LEN_MAX : step_count;
          ptr_d   = '0;
          timer_d = '0;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        if (!pause) begin
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (timer_q != '1) timer_d = timer_q + TIME_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          // Due steps fire one per cycle, so equal or earlier stamps drain back-to-back.
          if (tbl_time_q[ptr_q] <= timer_q) begin
            vec_d      = tbl_vec_q[ptr_q];
            step_idx_d = ptr_q;
            strobe_d   = 1'b1;
            ptr_d      = ptr_q + IDX_W'(1);
            if ({1'b0, ptr_q} == (len_q - (IDX_W+1)'(1))) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      ptr_q      <= '0;
      timer_q    <= '0;
      pre_q      <= '0;
      vec_q      <= '0;
      step_idx_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      vec_q      <= vec_d;
      step_idx_q <= step_idx_d;
      strobe_q   <= strobe_d;
    end
  end

  assign {i4, i3, i2, i1} = vec_q;
  assign step_idx         = step_idx_q;
  assign step_strobe      = strobe_q;
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);

endmodule

// File: doc/stim_step_sequencer.md
# stim_step_sequencer

Timed stimulus generator that sits directly upstream of the test-sequence FSMs. It drives the four stimulus lines i1..i4 from a programmable table of (time stamp, 4-bit vector) steps. Steps are played back against a prescaled time base, so a downstream FSM sees the same step-wise input schedule a testbench timing table describes.

## Interface
- NUM_STEPS, 13, table depth (1..16)
- IDX_W, 4, step index width; 2^IDX_W >= NUM_STEPS
- TIME_W, 16, time stamp and timer width
- TICK_DIV, 1, clock cycles per time unit (>= 1)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table entry to write
- cfg_time  in  TIME_W  time stamp for the entry
- cfg_vec  in  4  vector for the entry; bit0=i1, bit1=i2, bit2=i3, bit3=i4
- step_count  in  IDX_W+1  number of valid steps, sampled on accepted start
- start  in  1  begin playback
- pause  in  1  freeze time base while high
- i1, i2, i3, i4  out  1 each  registered stimulus lines
- step_idx  out  IDX_W  index of the last applied step
- step_strobe  out  1  one-cycle pulse on each applied step
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. i1..i4, step_idx, step_strobe, busy, done, timer, prescaler and step pointer all 0. All table entries are cleared to time 0, vec 0.
- Table writes are accepted in IDLE and DONE only. cfg_we in RUN is ignored. A cfg_addr >= NUM_STEPS is ignored.
- IDLE/DONE + start:
  - If step_count = 0, start is ignored and the state is unchanged.
  - Otherwise: latch len = min(step_count, NUM_STEPS); timer=0, prescaler=0, pointer=0; go to RUN; done=0.
  - Outputs i1..i4 hold their previous value until step 0 fires.
- start in RUN is ignored.
- RUN, each cycle with pause=0:
  - If table[ptr].time <= timer, apply the step: {i4,i3,i2,i1} <= vec, step_idx <= ptr, step_strobe=1, ptr++.
  - At most one step fires per cycle.
  - Equal or out-of-order time stamps fire on consecutive cycles.
  - Prescaler counts 0..TICK_DIV-1. Timer increments when the prescaler wraps. Timer saturates at 2^TIME_W-1 and does not wrap.
- When the step with ptr = len-1 fires, the state goes to DONE on the same edge. In DONE: done=1, busy=0, outputs hold the last vector.
- pause=1 in RUN: prescaler and timer hold, no step fires, step_strobe=0, outputs hold. pause is ignored outside RUN.
- Reset in any state, including mid-RUN, returns to the reset values on the next edge.

## Timing
- start sampled at edge E0 gives busy=1 after E0.
- Step p with time T (no pause, ordered table) fires at edge E0+1+T·TICK_DIV. New i1..i4 and step_strobe are visible after that edge.
- step_strobe is high exactly one cycle per applied step.
- done rises on the same edge as the last step's strobe.
- Each pause cycle delays every later step by exactly one cycle.
- Latency from table write to use: the write at edge W is visible to a start sampled at W+1 or later.

## Test plan
- Reset check: assert reset for 2 cycles mid-RUN -> i1..i4=0, busy=0, done=0, step_idx=0, table reads back as zero (playback with step_count=1 gives vec 0 at T=0).
- Basic schedule: TICK_DIV=1, table {(0,0x1),(2,0x3),(5,0xF)}, step_count=3, start at E0 -> vectors 0x1 at E0+1, 0x3 at E0+3, 0xF at E0+6. Three strobes. done at E0+6.
- Prescale: TICK_DIV=100, steps at times 0, 200, 700 (scaled to 0, 2, 7 units) -> strobes at E0+1, E0+201, E0+701.
- Pause: basic schedule with pause high for 4 cycles starting at E0+2 -> step 1 at E0+7, step 2 at E0+10.
- Boundaries:
  - Duplicate times (3,3) -> strobes on consecutive cycles.
  - step_count=20 clamps to 13.
  - step_count=0 -> start ignored.
  - cfg_we during RUN -> table unchanged.
- Restart: start in DONE -> outputs hold 0xF until step 0 re-fires, done drops after the start edge.
